// File: rtl/cv32e40p_ft_redundancy_manager.sv
// rtl/cv32e40p_ft_redundancy_manager.sv - per-replica health tracking for the FT voters
// Leaky-bucket error counters, HEALTHY/SUSPECT/BROKEN/PROBATION FSMs and aggregate status.
module cv32e40p_ft_redundancy_manager #(
   parameter int N_REPL             = 3,
   parameter int COUNT_BIT          = 8,
   parameter int INCREMENT          = 4,
   parameter int DECREMENT          = 1,
   parameter int SUSPECT_THRESHOLD  = 8,
   parameter int BREAKING_THRESHOLD = 32,
   parameter bit RECOVERY_EN        = 1'b1,
   parameter int PROBATION_CYCLES   = 256,
   parameter int PROB_BIT           = 9,
   parameter int EVT_CNT_BIT        = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_REPL-1:0]             err_detected_i,
   input  logic [N_REPL-1:0]             set_broken_i,
   input  logic [N_REPL-1:0]             clear_broken_i,
   output logic [N_REPL-1:0]             is_broken_o,
   output logic [N_REPL-1:0]             is_suspect_o,
   output logic [$clog2(N_REPL+1)-1:0]   num_broken_o,
   output logic                          fatal_o,
   output logic [EVT_CNT_BIT-1:0]        err_event_cnt_o
);

   localparam int NB_W = $clog2(N_REPL+1);

   localparam logic [1:0] S_HEALTHY   = 2'd0;
   localparam logic [1:0] S_SUSPECT   = 2'd1;
   localparam logic [1:0] S_BROKEN    = 2'd2;
   localparam logic [1:0] S_PROBATION = 2'd3;

   localparam logic [COUNT_BIT:0]   CNT_MAX  = {1'b0, {COUNT_BIT{1'b1}}};
   localparam logic [COUNT_BIT:0]   INC_W    = (COUNT_BIT+1)'(INCREMENT);
   localparam logic [COUNT_BIT:0]   DEC_W    = (COUNT_BIT+1)'(DECREMENT);
   localparam logic [COUNT_BIT-1:0] SUS_THR  = COUNT_BIT'(SUSPECT_THRESHOLD);
   localparam logic [COUNT_BIT-1:0] BRK_THR  = COUNT_BIT'(BREAKING_THRESHOLD);
   localparam logic [PROB_BIT-1:0]  PROB_LD  = PROB_BIT'(PROBATION_CYCLES);
   localparam logic [EVT_CNT_BIT-1:0] EVT_MAX = {EVT_CNT_BIT{1'b1}};
   localparam logic [NB_W-1:0]      FATAL_LVL = NB_W'(N_REPL-1);

   generate
      if (N_REPL < 3) begin : g_chk_repl
         $fatal(1, "N_REPL must be at least 3");
      end
      if (SUSPECT_THRESHOLD <= 0 || SUSPECT_THRESHOLD > BREAKING_THRESHOLD ||
          BREAKING_THRESHOLD >= (1 << COUNT_BIT)) begin : g_chk_thr
         $fatal(1, "thresholds must satisfy 0 < SUSPECT <= BREAKING < 2^COUNT_BIT");
      end
      if (PROBATION_CYCLES <= 0 || PROBATION_CYCLES >= (1 << PROB_BIT)) begin : g_chk_prob
         $fatal(1, "PROBATION_CYCLES must fit in PROB_BIT and be non-zero");
      end
      if (INCREMENT <= 0 || DECREMENT <= 0) begin : g_chk_step
         $fatal(1, "INCREMENT and DECREMENT must be positive");
      end
   endgenerate

   logic [1:0]             state_q [N_REPL];
   logic [1:0]             state_d [N_REPL];
   logic [COUNT_BIT-1:0]   cnt_q   [N_REPL];
   logic [COUNT_BIT-1:0]   cnt_d   [N_REPL];
   logic [PROB_BIT-1:0]    timer_q [N_REPL];
   logic [PROB_BIT-1:0]    timer_d [N_REPL];

   logic [N_REPL-1:0]      is_broken_q, is_broken_d;
   logic [N_REPL-1:0]      is_suspect_q, is_suspect_d;
   logic [NB_W-1:0]        num_broken_q, num_broken_d;
   logic                   fatal_q, fatal_d;
   logic [EVT_CNT_BIT-1:0] evt_cnt_q, evt_cnt_d;

   // Leaky-bucket step, done one bit wider so the clamps see the true result.
   function automatic logic [COUNT_BIT-1:0] step_cnt(input logic [COUNT_BIT-1:0] c,
                                                     input logic err);
      logic [COUNT_BIT:0] w;
      w = {1'b0, c};
      if (err) begin
         w = w + INC_W;
         if (w > CNT_MAX) w = CNT_MAX;
      end else if (w > DEC_W) begin
         w = w - DEC_W;
      end else begin
         w = '0;
      end
      return w[COUNT_BIT-1:0];
   endfunction

   always_comb begin
      for (int m = 0; m < N_REPL; m++) begin
         state_d[m] = state_q[m];
         cnt_d[m]   = cnt_q[m];
         timer_d[m] = timer_q[m];
         case (state_q[m])
            S_HEALTHY, S_SUSPECT: begin
               cnt_d[m] = step_cnt(cnt_q[m], err_detected_i[m]);
               if (cnt_d[m] >= BRK_THR)      state_d[m] = S_BROKEN;
               else if (cnt_d[m] >= SUS_THR) state_d[m] = S_SUSPECT;
               else                          state_d[m] = S_HEALTHY;
            end
            S_BROKEN: begin
               if (RECOVERY_EN && clear_broken_i[m]) begin
                  state_d[m] = S_PROBATION;
                  cnt_d[m]   = '0;
                  timer_d[m] = PROB_LD;
               end
            end
            default: begin
               // Any error during probation sends the replica straight back.
               if (err_detected_i[m]) begin
                  state_d[m] = S_BROKEN;
                  cnt_d[m]   = BRK_THR;
               end else begin
                  timer_d[m] = timer_q[m] - PROB_BIT'(1);
                  if (timer_d[m] == '0) begin
                     state_d[m] = S_HEALTHY;
                     cnt_d[m]   = '0;
                  end
               end
            end
         endcase
         if (set_broken_i[m]) state_d[m] = S_BROKEN;
      end
   end

   always_comb begin
      num_broken_d = '0;
      for (int m = 0; m < N_REPL; m++) begin
         is_broken_d[m]  = (state_d[m] == S_BROKEN) || (state_d[m] == S_PROBATION);
         is_suspect_d[m] = (state_d[m] == S_SUSPECT);
         num_broken_d    = num_broken_d + NB_W'(is_broken_d[m]);
      end
      fatal_d   = (num_broken_d >= FATAL_LVL);
      evt_cnt_d = evt_cnt_q;
      if (|err_detected_i && evt_cnt_q != EVT_MAX) evt_cnt_d = evt_cnt_q + EVT_CNT_BIT'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int m = 0; m < N_REPL; m++) begin
            state_q[m] <= S_HEALTHY;
            cnt_q[m]   <= '0;
            timer_q[m] <= '0;
         end
         is_broken_q  <= '0;
         is_suspect_q <= '0;
         num_broken_q <= '0;
         fatal_q      <= 1'b0;
         evt_cnt_q    <= '0;
      end else begin
         for (int m = 0; m < N_REPL; m++) begin
            state_q[m] <= state_d[m];
            cnt_q[m]   <= cnt_d[m];
            timer_q[m] <= timer_d[m];
         end
         is_broken_q  <= is_broken_d;
         is_suspect_q <= is_suspect_d;
         num_broken_q <= num_broken_d;
         fatal_q      <= fatal_d;
         evt_cnt_q    <= evt_cnt_d;
      end
   end

   assign is_broken_o     = is_broken_q;
   assign is_suspect_o    = is_suspect_q;
   assign num_broken_o    = num_broken_q;
   assign fatal_o         = fatal_q;
   assign err_event_cnt_o = evt_cnt_q;

endmodule
